encoder_16_to_4_queued: RTL

Registered 16-to-4 request encoder: the reverse direction of the team's active-low 4-to-16 decoder. Sixteen active-low request lines, one per source, are latched into a pending mask. Pending indices are emitted one at a time as 4-bit codes on a valid/ready handshake, and each served bit is cleared. It sits at the collection side of a decoded select bus and turns decoded strobes back into indices for a downstream consumer.

---
 rtl/encoder_16_to_4_queued_pkg.sv | 30 +++
 rtl/encoder_16_to_4_queued_if.sv | 34 +++
 rtl/encoder_16_to_4_queued_priority_encoder_16.sv | 28 ++
 rtl/encoder_16_to_4_queued.sv | 114 +++++++++++
 4 files changed

// File: rtl/encoder_16_to_4_queued_pkg.sv
// Shared widths, FSM state type and small helpers for the queued 16-to-4 request encoder.
// ROUND_ROBIN_EN selects rotating priority in the top; the package is identical either way.
package encoder_16_to_4_queued_pkg;

  localparam int unsigned Lines  = 16;
  localparam int unsigned CodeW  = 4;
  localparam int unsigned CountW = 5;

  typedef enum logic [0:0] {
    StIdle,
    StPresent
  } state_e;

  function automatic logic [Lines-1:0] onehot16(logic [CodeW-1:0] idx);
    logic [Lines-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [CountW-1:0] popcount16(logic [Lines-1:0] v);
    logic [CountW-1:0] n;
    n = '0;
    for (int i = 0; i < int'(Lines); i++) begin
      n = n + CountW'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/encoder_16_to_4_queued_if.sv
// Request/response bundle of the queued encoder: capture side, code handshake and status.
// The DUT attaches through the slave modport; the driving environment uses master.
interface encoder_16_to_4_queued_if;
  import encoder_16_to_4_queued_pkg::*;

  logic              enable;
  logic [Lines-1:0]  in;
  logic [CodeW-1:0]  out;
  logic              out_valid;
  logic              out_ready;
  logic [Lines-1:0]  pending;
  logic [CountW-1:0] count;

  modport master (
    output enable,
    output in,
    output out_ready,
    input  out,
    input  out_valid,
    input  pending,
    input  count
  );

  modport slave (
    input  enable,
    input  in,
    input  out_ready,
    output out,
    output out_valid,
    output pending,
    output count
  );

endinterface

// File: rtl/encoder_16_to_4_queued_priority_encoder_16.sv
// Combinational 16-line priority encoder: first set mask bit at or above start, wrapping 15 -> 0.
// With start tied to 0 this degenerates to plain lowest-index priority.
module priority_encoder_16
  import encoder_16_to_4_queued_pkg::*;
(
  input  logic [Lines-1:0] mask,
  input  logic [CodeW-1:0] start,
  output logic [CodeW-1:0] index,
  output logic             found
);

  logic [CodeW-1:0] probe;

  // Scan from farthest to nearest so the last hit written is the closest to start.
  always_comb begin
    index = '0;
    probe = '0;
    for (int i = int'(Lines) - 1; i >= 0; i--) begin
      probe = start + CodeW'(i);
      if (mask[probe]) begin
        index = probe;
      end
    end
  end

  assign found = |mask;

endmodule

// File: rtl/encoder_16_to_4_queued.sv
// Registered 16-to-4 request encoder: latches active-low requests and serves them one code per
// handshake. Define ROUND_ROBIN_EN for rotating priority; default build is fixed lowest-index.
module encoder_16_to_4_queued
  import encoder_16_to_4_queued_pkg::*;
(
  input logic                   clk,
  input logic                   reset,
  encoder_16_to_4_queued_if.slave bus
);

  state_e           state_q, state_d;
  logic [Lines-1:0] pending_q, pending_d;
  logic [CodeW-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;

  logic             handshake;
  logic [Lines-1:0] clear;
  logic [Lines-1:0] candidate;
  logic [CodeW-1:0] start;
  logic [CodeW-1:0] sel_index;
  logic             sel_found;

  assign handshake = (state_q == StPresent) && bus.out_ready;
  assign clear     = handshake ? onehot16(out_q) : '0;
  assign candidate = pending_q & ~clear;

  // Capture is OR'd in after the clear, so a bit that is re-requested while served stays set.
  always_comb begin
    pending_d = candidate;
    if (!bus.enable) begin
      pending_d = candidate | ~bus.in;
    end
  end

`ifdef ROUND_ROBIN_EN
  logic [CodeW-1:0] ptr_q, ptr_d;

  assign ptr_d = handshake ? out_q + CodeW'(1) : ptr_q;
  // The next pick in a handshake cycle already uses the freshly advanced pointer.
  assign start = ptr_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign start = '0;
`endif

  priority_encoder_16 u_prio (
    .mask  (candidate),
    .start (start),
    .index (sel_index),
    .found (sel_found)
  );

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    unique case (state_q)
      StIdle: begin
        if (sel_found) begin
          out_d   = sel_index;
          state_d = StPresent;
        end
      end
      StPresent: begin
        if (handshake) begin
          if (sel_found) begin
            out_d = sel_index;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign out_valid_d = (state_d == StPresent);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      pending_q   <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.pending   = pending_q;
  assign bus.count     = popcount16(pending_q);

  // A presented code always refers to a still-pending request.
  a_valid_is_pending: assert property (@(posedge clk) disable iff (reset)
    out_valid_q |-> pending_q[out_q]);

  a_stall_holds_out: assert property (@(posedge clk) disable iff (reset)
    (out_valid_q && !bus.out_ready) |=> (out_valid_q && $stable(out_q)));

  a_count_range: assert property (@(posedge clk) disable iff (reset)
    bus.count <= CountW'(Lines));

endmodule
